// File: rtl/seq_pkg.sv
// seq_pkg
//   Definitions shared by the serial sequence generator and the matching
//   sequence detector: the pattern length, the four selectable patterns,
//   the generator state encoding and a pattern lookup helper.
package seq_pkg;

  localparam int SEQ_PAT_LEN = 4;

  // Pattern table, indexed by the 2-bit lookfor_seq selector.
  localparam logic [SEQ_PAT_LEN-1:0] SEQ_PAT_00 = 4'b1011;
  localparam logic [SEQ_PAT_LEN-1:0] SEQ_PAT_01 = 4'b1101;
  localparam logic [SEQ_PAT_LEN-1:0] SEQ_PAT_10 = 4'b0110;
  localparam logic [SEQ_PAT_LEN-1:0] SEQ_PAT_11 = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } seq_state_t;

  function automatic logic [SEQ_PAT_LEN-1:0] seq_pattern(input logic [1:0] sel);
    logic [SEQ_PAT_LEN-1:0] pat;
    case (sel)
      2'b00:   pat = SEQ_PAT_00;
      2'b01:   pat = SEQ_PAT_01;
      2'b10:   pat = SEQ_PAT_10;
      default: pat = SEQ_PAT_11;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg
//   Parallel-load, MSB-out shift register. Load has priority over shift;
//   zeros are shifted in at the LSB end.
//
// Ports
//   clk      : clock, rising edge
//   reset    : synchronous active-low reset, clears the register
//   i_load   : load i_din into the register
//   i_shift  : shift left by one bit
//   i_din    : parallel load data
//   o_msb    : current most significant bit
module seq_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_din,
  output logic         o_msb
);

  logic [W-1:0] r_data;

  // W must be at least 2 for the shift slice below.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_din;
    end else if (i_shift) begin
      r_data <= {r_data[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_data[W-1];

endmodule

// File: rtl/sequence_generator.sv
// sequence_generator
//   Emits bursts of a selectable PAT_LEN-bit pattern on a serial line,
//   MSB first, optionally separated by a single 0 gap bit, and counts the
//   complete patterns emitted since reset.
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous active-low reset
//   start        : burst request, accepted only in IDLE
//   lookfor_seq  : pattern select (latched at start)
//   repeat_cnt   : patterns per burst (latched at start, 0 = empty burst)
//   gap_en       : insert one 0 bit between patterns (latched at start)
//   output_seq   : serial data
//   busy         : high in SEND and GAP
//   done         : one-cycle pulse in FIN
//   gseq_count   : wrapping count of complete patterns
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, output low
// SEND    | driving pattern bits, one per cycle
// GAP     | single 0 bit between two patterns of a burst
// FIN     | one-cycle end-of-burst marker, done high, start ignored
module sequence_generator
  import seq_pkg::*;
#(
  parameter int PAT_LEN = SEQ_PAT_LEN,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       lookfor_seq,
  input  logic [7:0]       repeat_cnt,
  input  logic             gap_en,
  output logic             output_seq,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] gseq_count
);

  localparam int               BIT_W    = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_LEN - 1);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;

  logic [PAT_LEN-1:0] r_pattern;
  logic [7:0]         r_remaining;
  logic               r_gap_en;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   r_gseq_count;

  logic [PAT_LEN-1:0] w_sel_pattern;
  logic [PAT_LEN-1:0] w_load_data;
  logic               w_accept;
  logic               w_last_bit;
  logic               w_last_pat;
  logic               w_load;
  logic               w_shift;
  logic               w_sr_msb;

  assign w_sel_pattern = PAT_LEN'(seq_pattern(lookfor_seq));

  // A burst with repeat_cnt = 0 is not "accepted": it skips straight to FIN
  // without touching the latched registers.
  assign w_accept   = (r_state == ST_IDLE) && start && (repeat_cnt != 8'd0);
  // Bit counter runs down; terminal count marks the pattern's last bit.
  assign w_last_bit = (r_state == ST_SEND) && (r_bit_cnt == '0);
  assign w_last_pat = (r_remaining == 8'd1);

  // The next pattern is reloaded on the last bit's edge, so a following GAP
  // cycle only has to gate the output; the shifter just holds.
  assign w_load      = w_accept || (w_last_bit && !w_last_pat);
  assign w_shift     = (r_state == ST_SEND) && (r_bit_cnt != '0);
  assign w_load_data = (r_state == ST_IDLE) ? w_sel_pattern : r_pattern;

  seq_shift_reg #(
    .W(PAT_LEN)
  ) u_shift_reg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_din   (w_load_data),
    .o_msb   (w_sr_msb)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (repeat_cnt != 8'd0) ? ST_SEND : ST_FIN;
        end
      end
      ST_SEND: begin
        if (w_last_bit) begin
          if (w_last_pat) begin
            w_state_nxt = ST_FIN;
          end else if (r_gap_en) begin
            w_state_nxt = ST_GAP;
          end else begin
            w_state_nxt = ST_SEND;
          end
        end
      end
      ST_GAP:  w_state_nxt = ST_SEND;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    output_seq = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      ST_SEND: begin
        output_seq = w_sr_msb;
        busy       = 1'b1;
      end
      ST_GAP:  busy = 1'b1;
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  // Burst bookkeeping: latched request, remaining patterns, bit position,
  // emitted-pattern counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pattern    <= '0;
      r_remaining  <= '0;
      r_gap_en     <= 1'b0;
      r_bit_cnt    <= '0;
      r_gseq_count <= '0;
    end else if (w_accept) begin
      r_pattern   <= w_sel_pattern;
      r_remaining <= repeat_cnt;
      r_gap_en    <= gap_en;
      r_bit_cnt   <= BIT_LAST;
    end else if (r_state == ST_SEND) begin
      if (w_last_bit) begin
        r_remaining  <= r_remaining - 8'd1;
        r_gseq_count <= r_gseq_count + CNT_W'(1);
        r_bit_cnt    <= BIT_LAST;
      end else begin
        r_bit_cnt <= r_bit_cnt - BIT_W'(1);
      end
    end
  end

  assign gseq_count = r_gseq_count;

endmodule

// File: tb/tb_sequence_generator.sv
module tb_sequence_generator;

  typedef struct {
    bit o;
    bit b;
    bit d;
    int cnt;
  } exp_t;

  localparam int HIST = 1024;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  lookfor_seq;
  logic [7:0]  repeat_cnt;
  logic        gap_en;

  logic        output_seq, busy, done;
  logic [15:0] gseq_count;
  logic        s_out, s_busy, s_done;
  logic [2:0]  s_count;

  int   checks   = 0;
  int   failures = 0;
  int   m_cnt    = 0;
  int   cyc      = 0;
  bit   chk_en   = 1'b0;
  exp_t q[$];

  bit out_hist  [HIST];
  bit busy_hist [HIST];
  bit done_hist [HIST];

  sequence_generator dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .lookfor_seq(lookfor_seq),
    .repeat_cnt (repeat_cnt),
    .gap_en     (gap_en),
    .output_seq (output_seq),
    .busy       (busy),
    .done       (done),
    .gseq_count (gseq_count)
  );

  // Narrow counter copy so the all-ones -> 0 wrap is reachable quickly.
  sequence_generator #(.CNT_W(3)) dut_s (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .lookfor_seq(lookfor_seq),
    .repeat_cnt (repeat_cnt),
    .gap_en     (gap_en),
    .output_seq (s_out),
    .busy       (s_busy),
    .done       (s_done),
    .gseq_count (s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] model_pat(input logic [1:0] sel);
    logic [3:0] tab [4];
    tab[0] = 4'b1011;
    tab[1] = 4'b1101;
    tab[2] = 4'b0110;
    tab[3] = 4'b1001;
    return tab[sel];
  endfunction

  // Expected cycle stream of one burst, starting with the cycle in which
  // start is presented.
  task automatic push_burst(input logic [1:0] sel, input int n, input bit g);
    logic [3:0] p;
    p = model_pat(sel);
    q.push_back('{1'b0, 1'b0, 1'b0, m_cnt});
    for (int k = 0; k < n; k++) begin
      for (int i = 3; i >= 0; i--) q.push_back('{p[i], 1'b1, 1'b0, m_cnt});
      m_cnt++;
      if (g && k < n - 1) q.push_back('{1'b0, 1'b1, 1'b0, m_cnt});
    end
    q.push_back('{1'b0, 1'b0, 1'b1, m_cnt});
  endtask

  function automatic logic [31:0] out_bits(input int s, input int len);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r = {r[30:0], out_hist[s + i]};
    return r;
  endfunction

  function automatic logic [31:0] busy_bits(input int s, input int len);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r = {r[30:0], busy_hist[s + i]};
    return r;
  endfunction

  // Compare process: every cycle, DUT outputs against the model stream
  // (or the idle expectation once the stream is exhausted).
  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (q.size() > 0) e = q.pop_front();
        else              e = '{1'b0, 1'b0, 1'b0, m_cnt};
        cyc++;
        if (cyc < HIST) begin
          out_hist[cyc]  = output_seq;
          busy_hist[cyc] = busy;
          done_hist[cyc] = done;
        end
        chk("output_seq", 32'(output_seq), 32'(e.o));
        chk("busy", 32'(busy), 32'(e.b));
        chk("done", 32'(done), 32'(e.d));
        chk("gseq_count", 32'(gseq_count), 32'(e.cnt) & 32'h0000FFFF);
        chk("s.output_seq", 32'(s_out), 32'(e.o));
        chk("s.busy", 32'(s_busy), 32'(e.b));
        chk("s.done", 32'(s_done), 32'(e.d));
        chk("s.gseq_count", 32'(s_count), 32'(e.cnt) & 32'h7);
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 600; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk(name, 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    q.delete();
    m_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic run_burst(input logic [1:0] sel, input int n, input bit g, output int s0);
    s0 = cyc + 1;
    push_burst(sel, n, g);
    lookfor_seq = sel;
    repeat_cnt  = 8'(n);
    gap_en      = g;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain("burst drained");
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int s, sa, sb;
    reset = 1'b0; start = 1'b0; lookfor_seq = 2'b00; repeat_cnt = 8'd0; gap_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset gseq_count", 32'(gseq_count), 32'd0);
    chk("reset busy/done/out", {29'd0, busy, done, output_seq}, 32'd0);
    m_cnt  = 0;
    chk_en = 1'b1;
    reset  = 1'b1;
    @(posedge clk); #1;

    // Single pattern 1011
    run_burst(2'b00, 1, 1'b0, s);
    chk("s1 bits", out_bits(s + 1, 4), 32'b1011);
    chk("s1 done cycle5", 32'(done_hist[s + 5]), 32'd1);
    chk("s1 count", 32'(gseq_count), 32'd1);

    // Three contiguous 1101
    do_reset();
    run_burst(2'b01, 3, 1'b0, s);
    chk("s2 bits", out_bits(s + 1, 12), 32'b110111011101);
    chk("s2 done cycle13", 32'(done_hist[s + 13]), 32'd1);
    chk("s2 no early done", 32'(done_hist[s + 12]), 32'd0);
    chk("s2 count", 32'(gseq_count), 32'd3);

    // Two 0110 with a gap bit
    do_reset();
    run_burst(2'b10, 2, 1'b1, s);
    chk("s3 bits", out_bits(s + 1, 9), 32'b011000110);
    chk("s3 busy 1-9", busy_bits(s + 1, 9), 32'h1FF);
    chk("s3 busy cycle10", 32'(busy_hist[s + 10]), 32'd0);
    chk("s3 done cycle10", 32'(done_hist[s + 10]), 32'd1);
    chk("s3 count", 32'(gseq_count), 32'd2);

    // Empty burst
    run_burst(2'b11, 0, 1'b1, s);
    chk("s4 done cycle1", 32'(done_hist[s + 1]), 32'd1);
    chk("s4 busy never", busy_bits(s, 4), 32'd0);
    chk("s4 count unchanged", 32'(gseq_count), 32'd2);

    // Mid-burst start/select change ignored, then reset during bit 2
    s = cyc + 1;
    push_burst(2'b00, 2, 1'b0);
    lookfor_seq = 2'b00; repeat_cnt = 8'd2; gap_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    lookfor_seq = 2'b11; repeat_cnt = 8'd5; gap_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    q.delete();
    m_cnt = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("s5 bits 1-2", out_bits(s + 1, 2), 32'b10);
    chk("s5 idle after reset", {29'd0, busy_hist[s + 3], done_hist[s + 3], out_hist[s + 3]}, 32'd0);
    chk("s5 count cleared", 32'(gseq_count), 32'd0);
    @(posedge clk); #1;

    // start held through FIN: ignored there, accepted the cycle after
    sa = cyc + 1;
    push_burst(2'b11, 1, 1'b1);
    push_burst(2'b00, 2, 1'b1);
    lookfor_seq = 2'b11; repeat_cnt = 8'd1; gap_en = 1'b1; start = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    sb = sa + 6;
    lookfor_seq = 2'b00; repeat_cnt = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain("b2b drained");
    @(posedge clk); #1;
    chk("s6 A bits", out_bits(sa + 1, 4), 32'b1001);
    chk("s6 A done", 32'(done_hist[sa + 5]), 32'd1);
    chk("s6 B bits", out_bits(sb + 1, 9), 32'b101101011);
    chk("s6 B done", 32'(done_hist[sb + 10]), 32'd1);
    chk("s6 count", 32'(gseq_count), 32'd3);

    // Counter wrap on the narrow instance
    do_reset();
    run_burst(2'b01, 7, 1'b0, s);
    chk("s7 narrow all-ones", 32'(s_count), 32'd7);
    run_burst(2'b10, 1, 1'b1, s);
    chk("s7 narrow wrap", 32'(s_count), 32'd0);
    chk("s7 wide count", 32'(gseq_count), 32'd8);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4, giving the pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 16, giving the emitted-pattern counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a burst, sampled on the clk edge.
REQ-006 SHALL have port lookfor_seq, input, 2 bits: selects the pattern to emit.
REQ-007 SHALL have port repeat_cnt, input, 8 bits: number of patterns in the burst.
REQ-008 SHALL have port gap_en, input, 1 bit: when 1, one 0-bit is inserted between consecutive patterns.
REQ-009 SHALL have port output_seq, output, 1 bit: serial output line, MSB of the pattern first.
REQ-010 SHALL have port busy, output, 1 bit: high while a burst is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a burst.
REQ-012 SHALL have port gseq_count, output, CNT_W bits: count of complete patterns emitted since reset.

Function
REQ-013 SHALL decode lookfor_seq to patterns as follows: 00 -> 1011, 01 -> 1101, 10 -> 0110, 11 -> 1001.
REQ-014 SHALL implement the states IDLE, SEND, GAP and FIN, and no others.
REQ-015 SHALL, in IDLE with start=1 and repeat_cnt>0, latch the pattern, repeat_cnt and gap_en, and enter SEND.
REQ-016 SHALL, in IDLE with start=1 and repeat_cnt=0, enter FIN without emitting anything and leave gseq_count unchanged.
REQ-017 SHALL drive the first pattern bit (MSB) on output_seq in the cycle immediately after start is accepted (latency 1), and hold each bit for exactly one cycle.
REQ-018 SHALL ignore start while in SEND, GAP or FIN, and SHALL not alter latched inputs when the live inputs change mid-burst.
REQ-019 SHALL, on the cycle driving the last bit of a pattern, decrement the remaining count and increment gseq_count at that clock edge.
REQ-020 SHALL wrap gseq_count from all-ones to 0.
REQ-021 SHALL, after a pattern with remaining>0, go to GAP for one cycle (output_seq=0) if latched gap_en=1, otherwise go directly back to SEND with the next MSB.
REQ-022 SHALL, after the last pattern, go to FIN for one cycle with done=1 and output_seq=0, and then return to IDLE.
REQ-023 SHALL hold busy=1 in SEND and GAP, and busy=0 in IDLE and FIN.
REQ-024 SHALL hold output_seq=0 in IDLE, GAP and FIN.
REQ-025 SHALL allow a start asserted in the FIN cycle to be ignored; a new burst may begin at the earliest on the cycle after FIN.

Reset
REQ-026 SHALL, when reset=0 at a clk edge, set state to IDLE, output_seq=0, busy=0, done=0 and gseq_count=0, and clear all latched registers.
REQ-027 SHALL give reset priority over start and abort any burst in progress without asserting done.

Structure
REQ-028 SHALL place the pattern table constants, PAT_LEN and the state encoding in the shared package seq_pkg, which sequence_detector also imports.
REQ-029 SHALL use one sub-module, seq_shift_reg: a PAT_LEN-bit parallel-load, MSB-out shift register with load and shift enables.

Verification
REQ-030 SHALL cover: reset; lookfor_seq=00, repeat_cnt=1, start pulse -> output_seq 1,0,1,1 on cycles 1-4; done at cycle 5; gseq_count=1.
REQ-031 SHALL cover: lookfor_seq=01, repeat_cnt=3, gap_en=0 -> 110111011101 contiguous; done at cycle 13; gseq_count=3.
REQ-032 SHALL cover: lookfor_seq=10, repeat_cnt=2, gap_en=1 -> 0110 0 0110; done at cycle 10; busy high for cycles 1-9.
REQ-033 SHALL cover: repeat_cnt=0 with start -> done at cycle 1; busy never high; count unchanged.
REQ-034 SHALL cover: start and a lookfor_seq change mid-burst -> both ignored; reset=0 at bit 2 -> next cycle IDLE, output_seq=0, gseq_count=0, no done.
REQ-035 SHALL cover: force gseq_count=16'hFFFF, then one pattern -> gseq_count=0.
